// File: rtl/alu_serial.sv
// alu_serial: bit-serial WIDTH-bit NAND/NOR/ADD/SUB through one 1-bit slice, LSB first
module alu_serial #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       s_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] sa, sb, sr, res;
    logic [CNT_W-1:0] cnt;
    logic [1:0] op;
    logic c, bs, rbit, cn, last, arith;
    always_comb begin
        arith = op[1];
        bs = (op == 2'b11) ? ~sb[0] : sb[0];
        rbit = arith ? (sa[0] ^ bs ^ c) : (op[0] ? ~(sa[0] | bs) : ~(sa[0] & bs));
        cn = (sa[0] & bs) | (sa[0] & c) | (bs & c);
        res = {rbit, sr[WIDTH-1:1]};
        last = cnt == CNT_W'(WIDTH - 1);
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            sa <= '0;
            sb <= '0;
            sr <= '0;
            cnt <= '0;
            op <= '0;
            c <= 1'b0;
            done <= 1'b0;
            z <= '0;
            cout <= 1'b0;
            zero <= 1'b1;
            ovf <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sa <= a;
                    sb <= b;
                    op <= s_op;
                    c <= s_op[1] & cin;
                    cnt <= '0;
                end
            end else begin
                sa <= sa >> 1;
                sb <= sb >> 1;
                sr <= res;
                c <= cn;
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    done <= 1'b1;
                    z <= res;
                    cout <= arith & cn;
                    // c still holds the carry into the MSB here
                    ovf <= arith & (c ^ cn);
                    zero <= res == '0;
                end
            end
        end
    end
    assign busy = state == RUN;
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed vector table plus multi-cycle corner sequences for alu_serial (WIDTH=4)
module tb_alu_serial;
    logic clk = 0, rst = 1, start = 0, cin = 0;
    logic [3:0] a = 0, b = 0;
    logic [1:0] s_op = 0;
    logic busy, done, cout, zero, ovf;
    logic [3:0] z;
    int n_run = 0, n_fail = 0;

    alu_serial #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .s_op(s_op),
        .busy(busy), .done(done), .z(z), .cout(cout), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a, b;
        logic cin;
        logic [3:0] z;
        logic cout, zero, ovf;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string name, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [3:0] av, input logic [3:0] bv, input logic ci);
        int lat;
        @(negedge clk);
        s_op = op; a = av; b = bv; cin = ci; start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_after_start", busy, 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 4);
        check("busy_at_done", busy, 0);
    endtask

    initial begin
        int ndone;
        logic [3:0] zc;
        vt[0]  = '{2'b10, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{2'b11, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{2'b10, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{2'b00, 4'b1100, 4'b1010, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{2'b01, 4'b1100, 4'b1010, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{2'b11, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{2'b10, 4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{2'b11, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{2'b10, 4'b0001, 4'b0010, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{2'b00, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        vt[10] = '{2'b01, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};
        vt[11] = '{2'b11, 4'b0110, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_z", z, 0);
        check("rst_cout", cout, 0);
        check("rst_zero", zero, 1);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 0;

        // consecutive calls start in the done cycle, so entries 3->4 are back-to-back NAND then NOR
        for (int i = 0; i < 12; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].cin);
            check($sformatf("v%0d_z", i), z, vt[i].z);
            check($sformatf("v%0d_cout", i), cout, vt[i].cout);
            check($sformatf("v%0d_zero", i), zero, vt[i].zero);
            check($sformatf("v%0d_ovf", i), ovf, vt[i].ovf);
        end

        // inputs and start disturbed during RUN must not change result or add a done
        @(negedge clk);
        s_op = 2'b10; a = 4'b0010; b = 4'b0011; cin = 0; start = 1;
        @(posedge clk); #1;
        ndone = 0; zc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i < 3) begin
                a = ~a; b = b + 4'd5; s_op = s_op + 2'd1; cin = ~cin; start = 1;
            end else start = 0;
            if (done) begin
                ndone++;
                zc = z;
            end
        end
        check("disturb_done_count", ndone, 1);
        check("disturb_z", zc, 4'b0101);
        check("disturb_idle", busy, 0);

        // reset on the 2nd RUN cycle aborts without a done pulse
        @(negedge clk);
        s_op = 2'b11; a = 4'b1001; b = 4'b0011; cin = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_z", z, 0);
        check("abort_zero", zero, 1);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        @(negedge clk);
        rst = 0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(2'b10, 4'b0010, 4'b0011, 1'b0);
        check("post_abort_z", z, 4'b0101);
        check("post_abort_cout", cout, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised successor to the 1-bit/4-bit ALU slices.
- Computes a WIDTH-bit NAND, NOR, ADD or SUB bit-serially, one bit per clock, LSB first, through a single internal 1-bit ALU slice that carries its state between cycles.
- Has a start/busy/done handshake, registered results and status flags.
- Sits between the operand register file and the writeback path, where area matters more than latency.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle (busy=0).
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry in for ADD/SUB; captured on accepted start.
- s_op  input  2  operation, captured on accepted start: 00 NAND, 01 NOR, 10 ADD, 11 SUB.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results update.
- z  output  WIDTH  result; holds the last completed value.
- cout  output  1  carry out of the MSB (ADD/SUB); 0 for logic ops.
- zero  output  1  z == 0.
- ovf  output  1  signed overflow (ADD/SUB); 0 for logic ops.

Behaviour:
- Reset: synchronous, active-high, dominant over all other inputs.
  - Outputs: busy=0, done=0, z=0, cout=0, zero=1, ovf=0.
  - Internal state: FSM=IDLE, bit counter=0, shift registers cleared.
- FSM states: IDLE and RUN.
- IDLE:
  - On a clock edge with start=1: latch a, b, cin, s_op.
  - Carry register <= cin when s_op[1]=1; otherwise carry register <= 0.
  - counter <= 0; go to RUN; busy=1 from the next cycle.
  - With start=0: stay in IDLE; all outputs hold.
- RUN, each edge:
  - Slice input: bit 0 of the A and B shift registers.
  - NAND: bit = ~(a&b).
  - NOR: bit = ~(a|b).
  - ADD: bit = a^b^c; c' = majority(a, b, c).
  - SUB: the slice uses ~b; result = a + ~b + cin, so cin=1 gives a-b.
  - The result bit shifts into the result register from the MSB end; the A and B shift registers shift right; the counter increments.
- Completion: on the edge where counter == WIDTH-1 (the last bit):
  - z <= assembled result; cout <= final carry (ADD/SUB only).
  - ovf <= (carry into MSB) XOR (carry out of MSB) (ADD/SUB only); zero <= (final z == 0).
  - FSM -> IDLE; done=1 for exactly one cycle; busy=0 in that same cycle.
- Latency: start accepted at edge k; done and the new z are visible after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- Back-to-back: start=1 while done=1 is accepted, since the FSM is IDLE in that cycle. There are no idle cycles between operations.
- start while busy=1: ignored, not queued.
- Input stability: changes to a, b, cin, s_op during RUN do not affect the result; only the captured copies are used.
- z, cout, zero, ovf update only at completion, never with partial results.
- Reset mid-RUN: the operation is aborted, outputs take their reset values, and no done pulse is issued.
- Wrap-around: ADD/SUB results are modulo 2^WIDTH; the carry goes to cout.

Test Plan (WIDTH=4):
- ADD a=0111 b=0001 cin=0 -> done 4 cycles after start; z=1000, cout=0, ovf=1, zero=0.
- SUB a=0101 b=0011 cin=1 -> z=0010, cout=1, ovf=0, zero=0.
- ADD a=1111 b=0001 cin=0 -> z=0000, cout=1, zero=1, ovf=0.
- NAND a=1100 b=1010 -> z=0111, cout=0, ovf=0; then NOR with the same operands issued during the done cycle -> z=0001, with busy=1 and no idle gap between the two operations.
- Start an ADD, toggle a/b/s_op and pulse start during RUN -> result matches the captured operands; exactly one done pulse.
- Start a SUB, assert rst on the 2nd RUN cycle -> busy=0, z=0, zero=1, no done pulse; a following ADD 0010+0011 -> z=0101.
